// File: rtl/switch_pkg.sv
// Shared switch types: routing LUT entry and config-packet header/data layouts.
package switch_pkg;

    localparam int ROUTE_LUT_ENTRIES = 32;

    typedef logic [4:0] node_id_t;

    typedef enum logic [3:0] {
        CFG_WR = 4'hC,
        CFG_RD = 4'hD
    } cfg_fmt_t;

    typedef struct packed {
        logic [4:0] req;
        node_id_t   dest;
        logic [4:0] out_sel;
    } route_lut_t;

    typedef struct packed {
        logic [3:0] fmt;
        node_id_t   dest;
        logic [4:0] req;
        logic [4:0] count;
        logic [4:0] start;
        logic [7:0] rsvd;
    } cfg_hdr_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [4:0]  req;
        node_id_t    dest;
        logic [4:0]  out_sel;
        logic [11:0] zero;
    } cfg_data_t;

    function automatic logic [31:0] pack_data(input logic [4:0] idx, input route_lut_t e);
        cfg_data_t d;
        d.idx     = idx;
        d.req     = e.req;
        d.dest    = e.dest;
        d.out_sel = e.out_sel;
        d.zero    = '0;
        return d;
    endfunction

endpackage

// File: rtl/route_compute_if.sv
// Routing-table bundle between route_lut_writer (drives) and route_compute (reads).
interface route_compute_if;
    import switch_pkg::*;

    route_lut_t [ROUTE_LUT_ENTRIES-1:0] route_lut;

    modport route_lut_writer (output route_lut);
    modport route_compute    (input  route_lut);

endinterface

// File: rtl/route_lut_writer.sv
// Config-packet decoder and routing LUT storage for route_compute.
// Optional readback of LUT entries is enabled by ROUTE_LUT_READBACK_EN.
module route_lut_writer
    import switch_pkg::*;
#(
    parameter node_id_t NODE        = 5'd1,
    parameter int       LUT_ENTRIES = ROUTE_LUT_ENTRIES,
    parameter int       OUT_SEL_W   = 5
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         in_valid,
    input  logic [31:0]                  in_flit,
    output logic                         in_ready,
    output route_lut_t [LUT_ENTRIES-1:0] route_lut,
    output logic                         err,
    output logic                         out_valid,
    output logic [31:0]                  out_flit,
    input  logic                         out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN
`ifdef ROUTE_LUT_READBACK_EN
        ,
        ST_READ
`endif
    } state_t;

    state_t     state, state_next;
    logic [4:0] rem, rem_next;
    logic       err_next;
    logic       lut_we;
    logic       accept;
    logic       rd_load;

    cfg_hdr_t               hdr;
    cfg_data_t              dat;
    logic [OUT_SEL_W-1:0]   wr_sel;

    assign hdr    = in_flit;
    assign dat    = in_flit;
    assign wr_sel = dat.out_sel;

`ifdef ROUTE_LUT_READBACK_EN
    assign in_ready = (state != ST_READ);
`else
    assign in_ready = 1'b1;
`endif
    assign accept = in_valid & in_ready;

    always_comb begin
        state_next = state;
        rem_next   = rem;
        err_next   = 1'b0;
        lut_we     = 1'b0;
        rd_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr.count == 5'd0) begin
                        err_next = 1'b1;
                    end else if (hdr.fmt == CFG_WR) begin
                        rem_next = hdr.count;
                        if (hdr.dest == NODE) begin
                            state_next = ST_WRITE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ST_DRAIN;
                        end
`ifdef ROUTE_LUT_READBACK_EN
                    end else if (hdr.fmt == CFG_RD) begin
                        // A read header carries no data flits, so a foreign one needs no drain.
                        if (hdr.dest == NODE) begin
                            rem_next   = hdr.count;
                            rd_load    = 1'b1;
                            state_next = ST_READ;
                        end else begin
                            err_next = 1'b1;
                        end
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    lut_we   = 1'b1;
                    rem_next = rem - 5'd1;
                    if (rem == 5'd1) state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    rem_next = rem - 5'd1;
                    if (rem == 5'd1) state_next = ST_IDLE;
                end
            end
`ifdef ROUTE_LUT_READBACK_EN
            ST_READ: begin
                if (out_valid && out_ready) begin
                    rem_next = rem - 5'd1;
                    if (rem == 5'd1) state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            err   <= err_next;
        end
    end

    // No write-through bypass: a same-cycle lookup sees the previous entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < LUT_ENTRIES; i++) route_lut[i] <= '0;
        end else if (lut_we) begin
            route_lut[dat.idx].req     <= dat.req;
            route_lut[dat.idx].dest    <= dat.dest;
            route_lut[dat.idx].out_sel <= wr_sel;
        end
    end

`ifdef ROUTE_LUT_READBACK_EN
    logic [4:0] ptr;
    logic [4:0] ptr_inc;

    assign ptr_inc = ptr + 5'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else if (rd_load) begin
            ptr       <= hdr.start;
            out_valid <= 1'b1;
            out_flit  <= pack_data(hdr.start, route_lut[hdr.start]);
        end else if (out_valid && out_ready) begin
            if (rem == 5'd1) begin
                out_valid <= 1'b0;
                out_flit  <= '0;
            end else begin
                ptr      <= ptr_inc;
                out_flit <= pack_data(ptr_inc, route_lut[ptr_inc]);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{hdr.req, hdr.rsvd, dat.zero};
`else
    assign out_valid = 1'b0;
    assign out_flit  = '0;

    logic unused_bits;
    assign unused_bits = ^{hdr.req, hdr.rsvd, hdr.start, dat.zero, out_ready, rd_load};
`endif

endmodule
